// File: rtl/audio_adc_capture.sv
// I2S ADC capture: synchronizes the codec bit stream into i_clk, deserializes left/right
// samples into one {left,right} word per frame and queues words in a small FWFT FIFO.
module audio_adc_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_AUD_BCLK,
    input  logic                      i_AUD_ADCLRCK,
    input  logic                      i_AUD_ADCDAT,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic                      i_clear_ovf,
    output logic [2*DATA_W-1:0]       o_audio_data,
    output logic                      o_audio_valid,
    input  logic                      i_audio_ready,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_overflow,
    output logic [CNT_W-1:0]          o_ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W + 2);
    localparam logic [BW-1:0] CNT_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] CNT_DW   = BW'(DATA_W);
    localparam logic [BW-1:0] CNT_SAT  = BW'(DATA_W + 1);

    typedef enum logic [1:0] {WAIT_L, LEFT, RIGHT} state_t;

    // Synchronizers: bit 2 = BCLK, bit 1 = LRCK, bit 0 = data.
    logic [2:0] sync1_reg, sync2_reg;
    logic       bclk_d3_reg;
    logic       lrck_prev_reg;

    state_t              state_reg, state_next;
    logic [BW-1:0]       bitcnt_reg, bitcnt_next;
    logic [DATA_W-1:0]   left_sr_reg, left_sr_next;
    logic [DATA_W-1:0]   right_sr_reg, right_sr_next;
    logic                en_frame_reg, en_frame_next;
    logic                frame_done_reg, frame_done_next;

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr_reg, rd_ptr_reg;
    logic                overflow_reg;
    logic [CNT_W-1:0]    ovf_count_reg;

    logic bclk_rise, lrck_s, dat_s, lrck_fall, lrck_rise;
    logic full, empty, pop, push_req, do_push, ovf_event;

    assign bclk_rise = sync2_reg[2] & ~bclk_d3_reg;
    assign lrck_s    = sync2_reg[1];
    assign dat_s     = sync2_reg[0];
    // LRCK is compared against its value at the previous BCLK rise, so it is only judged when stable.
    assign lrck_fall = bclk_rise & lrck_prev_reg & ~lrck_s;
    assign lrck_rise = bclk_rise & ~lrck_prev_reg & lrck_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            bclk_d3_reg    <= 1'b0;
            lrck_prev_reg  <= 1'b0;
            state_reg      <= WAIT_L;
            bitcnt_reg     <= '0;
            left_sr_reg    <= '0;
            right_sr_reg   <= '0;
            en_frame_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            sync1_reg      <= {i_AUD_BCLK, i_AUD_ADCLRCK, i_AUD_ADCDAT};
            sync2_reg      <= sync1_reg;
            bclk_d3_reg    <= sync2_reg[2];
            if (bclk_rise)
                lrck_prev_reg <= lrck_s;
            state_reg      <= state_next;
            bitcnt_reg     <= bitcnt_next;
            left_sr_reg    <= left_sr_next;
            right_sr_reg   <= right_sr_next;
            en_frame_reg   <= en_frame_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bitcnt_next     = bitcnt_reg;
        left_sr_next    = left_sr_reg;
        right_sr_next   = right_sr_reg;
        en_frame_next   = en_frame_reg;
        frame_done_next = 1'b0;
        if (bclk_rise) begin
            case (state_reg)
                WAIT_L: begin
                    if (lrck_fall) begin
                        state_next    = LEFT;
                        bitcnt_next   = '0;
                        en_frame_next = i_enable;
                    end
                end
                LEFT: begin
                    if (lrck_rise) begin
                        // A short left channel cannot form a frame: resync on the next left start.
                        state_next  = (bitcnt_reg >= CNT_DW) ? RIGHT : WAIT_L;
                        bitcnt_next = '0;
                    end else begin
                        if (bitcnt_reg != CNT_SAT)
                            bitcnt_next = bitcnt_reg + 1'b1;
                        if (bitcnt_reg < CNT_DW)
                            left_sr_next = {left_sr_reg[DATA_W-2:0], dat_s};
                    end
                end
                RIGHT: begin
                    if (lrck_fall) begin
                        state_next    = LEFT;
                        bitcnt_next   = '0;
                        en_frame_next = i_enable;
                    end else begin
                        if (bitcnt_reg != CNT_SAT)
                            bitcnt_next = bitcnt_reg + 1'b1;
                        if (bitcnt_reg < CNT_DW)
                            right_sr_next = {right_sr_reg[DATA_W-2:0], dat_s};
                        if (bitcnt_reg == CNT_LAST)
                            frame_done_next = 1'b1;
                    end
                end
                default: state_next = WAIT_L;
            endcase
        end
    end

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    assign pop       = ~empty & i_audio_ready;
    assign push_req  = frame_done_reg & i_enable & en_frame_reg;
    assign do_push   = push_req & ~i_flush & (~full | pop);
    assign ovf_event = push_req & ~i_flush & full & ~pop;

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= {left_sr_reg, right_sr_reg};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            ovf_count_reg <= '0;
        end else begin
            if (i_flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (do_push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (ovf_event) begin
                overflow_reg <= 1'b1;
                if (i_clear_ovf)
                    ovf_count_reg <= CNT_W'(1);
                else if (~&ovf_count_reg)
                    ovf_count_reg <= ovf_count_reg + 1'b1;
            end else if (i_clear_ovf) begin
                overflow_reg  <= 1'b0;
                ovf_count_reg <= '0;
            end
        end
    end

    assign o_audio_valid = ~empty;
    assign o_audio_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign o_level       = wr_ptr_reg - rd_ptr_reg;
    assign o_overflow    = overflow_reg;
    assign o_ovf_count   = ovf_count_reg;
endmodule

// File: tb/tb_audio_adc_capture.sv
// Directed bench for audio_adc_capture: drives an I2S stream (BCLK = clk/8, 18-bit slots)
// and checks FIFO contents, occupancy, overflow, enable gating, resync, flush and reset.
module tb_audio_adc_capture;
    localparam int SLOT = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bclk = 1'b0, lrck = 1'b1, dat = 1'b0;
    logic        enable = 1'b0, flush = 1'b0, clear_ovf = 1'b0, ready = 1'b0;
    logic [31:0] audio_data;
    logic        audio_valid;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] ovf_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_cycles = 0;
    logic [31:0] popq [$];

    always #5 clk = ~clk;

    audio_adc_capture #(.DATA_W(16), .DEPTH(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .i_enable(enable), .i_flush(flush), .i_clear_ovf(clear_ovf),
        .o_audio_data(audio_data), .o_audio_valid(audio_valid), .i_audio_ready(ready),
        .o_level(level), .o_overflow(overflow), .o_ovf_count(ovf_count)
    );

    // Records every accepted word (valid && ready seen mid-cycle means a pop at the next edge).
    always @(negedge clk) begin
        if (audio_valid) valid_cycles++;
        if (audio_valid && ready) popq.push_back(audio_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic l, input logic d, input logic pulse_rdy, input logic do_rst);
        bclk = 1'b0; lrck = l; dat = d;
        if (do_rst) rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        bclk = 1'b1;
        tick(); tick(); tick();
        if (pulse_rdy) ready = 1'b1;
        tick();
        if (pulse_rdy) ready = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int rslot,
                              input int en_k, input int rst_k, input logic pulse_rdy);
        for (int k = 0; k < SLOT; k++) begin
            send_bit(1'b0, (k >= 1 && k <= 16) ? l[16-k] : 1'b0, 1'b0, k == rst_k);
            if (k == en_k) enable = 1'b1;
        end
        for (int k = 0; k < rslot; k++)
            send_bit(1'b1, (k >= 1 && k <= 16) ? r[16-k] : 1'b0, pulse_rdy && (k == 16), 1'b0);
    endtask

    task automatic test_reset();
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", audio_valid); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_cmp++; if (ovf_count !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", ovf_count); end
        n_cmp++; if (audio_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", audio_data); end
        $display("reset: valid=%b level=%0d ovf=%b cnt=%0d", audio_valid, level, overflow, ovf_count);
    endtask

    task automatic test_basic();
        logic [15:0] ls [2] = '{16'hA5C3, 16'h8001};
        logic [15:0] rs [2] = '{16'h1234, 16'h7FFE};
        int v0;
        enable = 1'b1; ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            popq.delete(); v0 = valid_cycles;
            send_frame(ls[i], rs[i], SLOT, -1, -1, 1'b0);
            n_cmp++;
            if (popq.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", popq.size()); end
            else if (popq[0] !== {ls[i], rs[i]}) begin n_bad++; $display("FAIL basic_data: got %h want %h", popq[0], {ls[i], rs[i]}); end
            n_cmp++;
            if (valid_cycles - v0 != 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles - v0); end
            $display("basic frame %0d: words=%0d valid_cycles=%0d", i, popq.size(), valid_cycles - v0);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] l, r;
        ready = 1'b0; popq.delete();
        for (int i = 0; i < 8; i++) begin
            l = 16'h1100 + 16'(i); r = 16'h2200 + 16'(i);
            send_frame(l, r, SLOT, -1, -1, 1'b0);
        end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level8: got %0d want 8", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
        send_frame(16'hDEAD, 16'hBEEF, SLOT, -1, -1, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (ovf_count !== 16'd1) begin n_bad++; $display("FAIL ovf_count: got %0d want 1", ovf_count); end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level_hold: got %0d want 8", level); end
        ready = 1'b1;
        repeat (12) tick();
        n_cmp++; if (popq.size() != 8) begin n_bad++; $display("FAIL ovf_drain_count: got %0d want 8", popq.size()); end
        for (int i = 0; i < 8 && i < popq.size(); i++) begin
            l = 16'h1100 + 16'(i); r = 16'h2200 + 16'(i);
            n_cmp++;
            if (popq[i] !== {l, r}) begin n_bad++; $display("FAIL ovf_drain_word%0d: got %h want %h", i, popq[i], {l, r}); end
        end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL ovf_drain_level: got %0d want 0", level); end
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clear_flag: got %b want 0", overflow); end
        n_cmp++; if (ovf_count !== 16'd0) begin n_bad++; $display("FAIL clear_count: got %0d want 0", ovf_count); end
        $display("overflow: drained=%0d ovf=%b cnt=%0d", popq.size(), overflow, ovf_count);
    endtask

    task automatic test_full_push_pop();
        logic [15:0] l, r;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            l = 16'h3300 + 16'(i); r = 16'h4400 + 16'(i);
            send_frame(l, r, SLOT, -1, -1, 1'b0);
        end
        popq.delete();
        send_frame(16'h5555, 16'hAAAA, SLOT, -1, -1, 1'b1);
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL fullpp_level: got %0d want 8", level); end
        n_cmp++; if (ovf_count !== 16'd0) begin n_bad++; $display("FAIL fullpp_count: got %0d want 0", ovf_count); end
        n_cmp++;
        if (popq.size() != 1) begin n_bad++; $display("FAIL fullpp_pop_count: got %0d want 1", popq.size()); end
        else if (popq[0] !== 32'h33004400) begin n_bad++; $display("FAIL fullpp_pop_word: got %h want 33004400", popq[0]); end
        ready = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if (popq.size() != 9) begin n_bad++; $display("FAIL fullpp_drain_count: got %0d want 9", popq.size()); end
        else if (popq[1] !== 32'h33014401 || popq[8] !== 32'h5555AAAA) begin
            n_bad++; $display("FAIL fullpp_order: got %h,%h want 33014401,5555aaaa", popq[1], popq[8]);
        end
        $display("full push+pop: level_after=%0d words=%0d", level, popq.size());
    endtask

    task automatic test_enable_mid();
        ready = 1'b1; enable = 1'b0; popq.delete();
        send_frame(16'h0F0F, 16'hF0F0, SLOT, 5, -1, 1'b0);
        send_frame(16'h1357, 16'h2468, SLOT, -1, -1, 1'b0);
        n_cmp++;
        if (popq.size() != 1) begin n_bad++; $display("FAIL enable_count: got %0d want 1", popq.size()); end
        else if (popq[0] !== 32'h13572468) begin n_bad++; $display("FAIL enable_data: got %h want 13572468", popq[0]); end
        $display("enable mid-left: words=%0d", popq.size());
    endtask

    task automatic test_short_right();
        ready = 1'b1; enable = 1'b1; popq.delete();
        send_frame(16'h7777, 16'h8888, 11, -1, -1, 1'b0);
        send_frame(16'hC001, 16'h0BAD, SLOT, -1, -1, 1'b0);
        n_cmp++;
        if (popq.size() != 1) begin n_bad++; $display("FAIL short_count: got %0d want 1", popq.size()); end
        else if (popq[0] !== 32'hC0010BAD) begin n_bad++; $display("FAIL short_data: got %h want c0010bad", popq[0]); end
        $display("short right: words=%0d", popq.size());
    endtask

    task automatic test_flush_reset();
        logic [15:0] l;
        ready = 1'b0; popq.delete();
        for (int i = 0; i < 5; i++) begin
            l = 16'h6000 + 16'(i);
            send_frame(l, ~l, SLOT, -1, -1, 1'b0);
        end
        n_cmp++; if (level !== 4'd5) begin n_bad++; $display("FAIL flush_pre_level: got %0d want 5", level); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", level); end
        n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", audio_valid); end
        ready = 1'b1;
        send_frame(16'h9999, 16'h6666, SLOT, -1, 6, 1'b0);
        n_cmp++; if (popq.size() != 0) begin n_bad++; $display("FAIL rst_partial: got %0d words want 0", popq.size()); end
        send_frame(16'h4321, 16'h8765, SLOT, -1, -1, 1'b0);
        n_cmp++;
        if (popq.size() != 1) begin n_bad++; $display("FAIL rst_first_count: got %0d want 1", popq.size()); end
        else if (popq[0] !== 32'h43218765) begin n_bad++; $display("FAIL rst_first_data: got %h want 43218765", popq[0]); end
        $display("flush/reset: words_after_reset=%0d level=%0d", popq.size(), level);
    endtask

    initial begin
        repeat (5) tick();
        rst = 1'b0;
        tick();
        test_reset();
        for (int i = 0; i < 2; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_enable_mid();
        test_short_right();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
